// File: rtl/reg_file_n.sv
// Multi-port register file: three combinational reads, two write ports and a sequential clear sweep.
// Define REG_FILE_N_BYPASS_EN to forward committing write data straight to the read ports.
module reg_file_n #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Rd_Addr,
    input  logic [ADDR_W-1:0] Rs_Addr,
    input  logic [ADDR_W-1:0] Rm_Addr,
    input  logic              Rd_Wen,
    input  logic              Rs_Wen,
    input  logic [DATA_W-1:0] Rd_Data,
    input  logic [DATA_W-1:0] Rs_Data,
    input  logic              Clear,
    output logic [DATA_W-1:0] Rd_Out,
    output logic [DATA_W-1:0] Rs_Out,
    output logic [DATA_W-1:0] Rm_Out,
    output logic              Busy,
    output logic              Clear_Done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              clear_done_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              busy;

    assign busy       = (state_q == StClear);
    assign Busy       = busy;
    assign Clear_Done = clear_done_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (Clear) begin
                        state_q <= StClear;
                        ptr_q   <= '0;
                    end
                end
                StClear: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q      <= StIdle;
                        clear_done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Rs is written after Rd so it wins on an address collision.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (busy) begin
            mem_q[ptr_q] <= '0;
        end else begin
            if (Rd_Wen) begin
                mem_q[Rd_Addr] <= Rd_Data;
            end
            if (Rs_Wen) begin
                mem_q[Rs_Addr] <= Rs_Data;
            end
        end
    end

`ifdef REG_FILE_N_BYPASS_EN
    logic fwd_en;
    logic rd_fwd_en;
    logic rs_fwd_en;

    assign fwd_en    = !busy && !Reset;
    assign rd_fwd_en = fwd_en && Rd_Wen;
    assign rs_fwd_en = fwd_en && Rs_Wen;

    always_comb begin
        Rd_Out = mem_q[Rd_Addr];
        if (rs_fwd_en && (Rs_Addr == Rd_Addr)) begin
            Rd_Out = Rs_Data;
        end else if (rd_fwd_en) begin
            Rd_Out = Rd_Data;
        end
    end

    always_comb begin
        Rs_Out = mem_q[Rs_Addr];
        if (rs_fwd_en) begin
            Rs_Out = Rs_Data;
        end else if (rd_fwd_en && (Rd_Addr == Rs_Addr)) begin
            Rs_Out = Rd_Data;
        end
    end

    always_comb begin
        Rm_Out = mem_q[Rm_Addr];
        if (rs_fwd_en && (Rs_Addr == Rm_Addr)) begin
            Rm_Out = Rs_Data;
        end else if (rd_fwd_en && (Rd_Addr == Rm_Addr)) begin
            Rm_Out = Rd_Data;
        end
    end
`else
    assign Rd_Out = mem_q[Rd_Addr];
    assign Rs_Out = mem_q[Rs_Addr];
    assign Rm_Out = mem_q[Rm_Addr];
`endif

endmodule

// File: tb/tb_reg_file_n.sv
// Self-checking bench for reg_file_n: directed steps plus random traffic against an array model.
module tb_reg_file_n;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] Rd_Addr, Rs_Addr, Rm_Addr;
    logic          Rd_Wen, Rs_Wen, Clear;
    logic [DW-1:0] Rd_Data, Rs_Data;
    logic [DW-1:0] Rd_Out, Rs_Out, Rm_Out;
    logic          Busy, Clear_Done;

    logic [5:0]    w_Rd_Addr, w_Rs_Addr, w_Rm_Addr;
    logic          w_Rd_Wen, w_Rs_Wen, w_Clear;
    logic [31:0]   w_Rd_Data, w_Rs_Data;
    logic [31:0]   w_Rd_Out, w_Rs_Out, w_Rm_Out;
    logic          w_Busy, w_Clear_Done;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] model [DEPTH];

    reg_file_n #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clock(Clock), .Reset(Reset),
        .Rd_Addr(Rd_Addr), .Rs_Addr(Rs_Addr), .Rm_Addr(Rm_Addr),
        .Rd_Wen(Rd_Wen), .Rs_Wen(Rs_Wen), .Rd_Data(Rd_Data), .Rs_Data(Rs_Data),
        .Clear(Clear), .Rd_Out(Rd_Out), .Rs_Out(Rs_Out), .Rm_Out(Rm_Out),
        .Busy(Busy), .Clear_Done(Clear_Done)
    );

    reg_file_n #(.DATA_W(32), .ADDR_W(6)) dut_w (
        .Clock(Clock), .Reset(Reset),
        .Rd_Addr(w_Rd_Addr), .Rs_Addr(w_Rs_Addr), .Rm_Addr(w_Rm_Addr),
        .Rd_Wen(w_Rd_Wen), .Rs_Wen(w_Rs_Wen), .Rd_Data(w_Rd_Data), .Rs_Data(w_Rs_Data),
        .Clear(w_Clear), .Rd_Out(w_Rd_Out), .Rs_Out(w_Rs_Out), .Rm_Out(w_Rm_Out),
        .Busy(w_Busy), .Clear_Done(w_Clear_Done)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Value a read port should show now; forwarding only when the bench knows a write will commit.
    function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a, input bit fwd_ok);
        logic [DW-1:0] v;
        v = model[a];
`ifdef REG_FILE_N_BYPASS_EN
        if (fwd_ok) begin
            if (Rd_Wen && Rd_Addr == a) v = Rd_Data;
            if (Rs_Wen && Rs_Addr == a) v = Rs_Data;
        end
`else
        if (fwd_ok) v = model[a];
`endif
        return v;
    endfunction

    task automatic commit();
        if (Rd_Wen) model[Rd_Addr] = Rd_Data;
        if (Rs_Wen) model[Rs_Addr] = Rs_Data;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        bit found;
        logic [DW-1:0] exp_v;

        Rd_Addr = '0; Rs_Addr = '0; Rm_Addr = '0; Rd_Wen = 0; Rs_Wen = 0;
        Rd_Data = '0; Rs_Data = '0; Clear = 0;
        w_Rd_Addr = '0; w_Rs_Addr = '0; w_Rm_Addr = '0; w_Rd_Wen = 0; w_Rs_Wen = 0;
        w_Rd_Data = '0; w_Rs_Data = '0; w_Clear = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        tick();
        tick();
        Reset = 0;
        check("rst_busy", Busy, 0);
        check("rst_done", Clear_Done, 0);
        for (int i = 0; i < DEPTH; i++) begin
            Rm_Addr = AW'(i);
            #1;
            check("rst_read", Rm_Out, 16'h0000);
            tick();
        end

        // Same-address dual write: Rs wins.
        Rd_Wen = 1; Rd_Addr = 3; Rd_Data = 16'hA5A5;
        Rs_Wen = 1; Rs_Addr = 3; Rs_Data = 16'h5A5A; Rm_Addr = 3;
        #1;
        check("dual_same_cycle", Rm_Out, expect_rd(4'd3, 1'b1));
        commit();
        tick();
        Rd_Wen = 0; Rs_Wen = 0;
        #1;
        check("dual_same_addr", Rm_Out, 16'h5A5A);
        tick();

        repeat (150) begin
            Rd_Addr = AW'($urandom); Rs_Addr = AW'($urandom); Rm_Addr = AW'($urandom);
            Rd_Wen = 1'($urandom); Rs_Wen = 1'($urandom);
            Rd_Data = DW'($urandom); Rs_Data = DW'($urandom);
            #1;
            check("rand_rd", Rd_Out, expect_rd(Rd_Addr, 1'b1));
            check("rand_rs", Rs_Out, expect_rd(Rs_Addr, 1'b1));
            check("rand_rm", Rm_Out, expect_rd(Rm_Addr, 1'b1));
            commit();
            tick();
        end
        Rd_Wen = 0; Rs_Wen = 0;

        // Fill 0x1111*i, then one clear sweep with a write attempted mid-sweep.
        for (int i = 0; i < DEPTH; i++) begin
            Rd_Wen = 1; Rd_Addr = AW'(i); Rd_Data = DW'(16'h1111 * i);
            commit();
            tick();
        end
        Rd_Wen = 0;
        Clear = 1;
        tick();
        Clear = 0;
        busy_cnt = 0;
        done_cnt = 0;
        repeat (24) begin
            if (Busy) begin
                Rd_Wen = (busy_cnt == 8); Rd_Addr = 7; Rd_Data = 16'hFFFF;
                Rm_Addr = (busy_cnt == 8) ? 4'd7 : AW'($urandom);
                #1;
                check("sweep_read", Rm_Out, (int'(Rm_Addr) < busy_cnt) ? 16'h0 : model[Rm_Addr]);
                busy_cnt++;
            end else begin
                Rd_Wen = 0;
            end
            if (Clear_Done) done_cnt++;
            tick();
        end
        Rd_Wen = 0;
        check("sweep_busy_cycles", busy_cnt, 16);
        check("sweep_done_pulses", done_cnt, 1);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            Rm_Addr = AW'(i);
            #1;
            check("post_sweep_read", Rm_Out, model[i]);
            tick();
        end

        // Clear held high: new sweep starts on the edge after Clear_Done rises.
        Clear = 1;
        tick();
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (Clear_Done) found = 1;
            else tick();
        end
        check("held_done_seen", found, 1);
        if (found) begin
            check("held_idle_at_done", Busy, 0);
            tick();
            check("held_restart", Busy, 1);
        end
        Clear = 0;
        for (int c = 0; c < 40 && Busy; c++) tick();
        check("held_exit", Busy, 0);
        tick();

        // Reset mid-sweep, with a write presented during reset.
        for (int i = 0; i < DEPTH; i++) begin
            Rd_Wen = 1; Rd_Addr = AW'(i); Rd_Data = DW'($urandom) | 16'h0001;
            commit();
            tick();
        end
        Rd_Wen = 0;
        Clear = 1;
        tick();
        Clear = 0;
        repeat (5) tick();
        check("pre_reset_busy", Busy, 1);
        Reset = 1;
        Rd_Wen = 1; Rd_Addr = 4; Rd_Data = 16'hBAD0; Rm_Addr = 4;
        #1;
        check("reset_busy_low", Busy, 0);
        check("reset_done_low", Clear_Done, 0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        tick();
        check("reset_write_dropped", Rm_Out, 16'h0000);
        Reset = 0;
        Rd_Wen = 0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            Rm_Addr = AW'(i);
            #1;
            check("after_reset_read", Rm_Out, model[i]);
            if (Clear_Done) done_cnt++;
            if (Busy) busy_cnt++;
            tick();
        end
        check("after_reset_no_done", done_cnt, 0);
        check("after_reset_no_busy", busy_cnt, 0);
        Rd_Wen = 1; Rd_Addr = 2; Rd_Data = 16'h1234;
        commit();
        tick();
        Rd_Wen = 0; Rm_Addr = 2;
        #1;
        check("after_reset_write", Rm_Out, 16'h1234);
        tick();

        // Same-cycle read of a committing write.
        Rd_Wen = 1; Rd_Addr = 9; Rd_Data = 16'hBEEF; Rm_Addr = 9;
`ifdef REG_FILE_N_BYPASS_EN
        exp_v = 16'hBEEF;
`else
        exp_v = 16'h0000;
`endif
        #1;
        check("bypass_same_cycle", Rm_Out, exp_v);
        commit();
        tick();
        Rd_Wen = 0;
        #1;
        check("bypass_next_cycle", Rm_Out, 16'hBEEF);
        tick();

        // Wide configuration: 32-bit data, 64 entries.
        w_Rd_Wen = 1; w_Rd_Addr = 63; w_Rd_Data = 32'hDEADBEEF;
        w_Rs_Addr = 63; w_Rm_Addr = 63;
        tick();
        w_Rd_Wen = 0;
        #1;
        check("wide_rd", w_Rd_Out, 32'hDEADBEEF);
        check("wide_rs", w_Rs_Out, 32'hDEADBEEF);
        check("wide_rm", w_Rm_Out, 32'hDEADBEEF);
        w_Clear = 1;
        tick();
        w_Clear = 0;
        busy_cnt = 0;
        done_cnt = 0;
        repeat (80) begin
            if (w_Busy) busy_cnt++;
            if (w_Clear_Done) done_cnt++;
            tick();
        end
        check("wide_busy_cycles", busy_cnt, 64);
        check("wide_done_pulses", done_cnt, 1);
        check("wide_cleared", w_Rm_Out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
